// File: rtl/cl_ddr_scrubber.sv
// Write-only AXI master that scrubs a DDR page range with full 4 KiB bursts of a
// replicated 32-bit pattern, one burst outstanding at a time.
module cl_ddr_scrubber #(
  parameter logic [15:0] AXI_ID = 16'h0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         scrb_enable,
  input  logic [63:0]  scrb_start,
  input  logic [63:0]  scrb_end,
  input  logic [31:0]  scrb_pattern,
  output logic [63:0]  scrb_addr,
  output logic [2:0]   scrb_state,
  output logic         scrb_done,
  output logic         scrb_err,
  output logic [15:0]  awid,
  output logic [63:0]  awaddr,
  output logic [7:0]   awlen,
  output logic [2:0]   awsize,
  output logic         awvalid,
  input  logic         awready,
  output logic [15:0]  wid,
  output logic [511:0] wdata,
  output logic [63:0]  wstrb,
  output logic         wlast,
  output logic         wvalid,
  input  logic         wready,
  input  logic [15:0]  bid,
  input  logic [1:0]   bresp,
  input  logic         bvalid,
  output logic         bready
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ADDR = 3'd1,
    DATA = 3'd2,
    RESP = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic        en_q, start_q;
  logic [51:0] page_q, page_d;   // addresses are tracked as 4 KiB page numbers
  logic [51:0] end_q, end_d;
  logic [51:0] page_inc;
  logic [31:0] pat_q, pat_d;
  logic [5:0]  beat_q, beat_d;
  logic        err_d;

  // Only page numbers are used; bid is irrelevant with a single outstanding ID.
  logic unused_inputs;
  assign unused_inputs = ^{bid, scrb_start[11:0], scrb_end[11:0]};

  assign page_inc = page_q + 52'd1;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    state_d = state_q;
    page_d  = page_q;
    end_d   = end_q;
    pat_d   = pat_q;
    beat_d  = beat_q;
    err_d   = scrb_err;
    unique case (state_q)
      IDLE: begin
        if (start_q) begin
          page_d  = scrb_start[63:12];
          end_d   = scrb_end[63:12];
          pat_d   = scrb_pattern;
          err_d   = 1'b0;
          state_d = (scrb_start[63:12] >= scrb_end[63:12]) ? DONE : ADDR;
        end
      end
      ADDR: begin
        if (awvalid && awready) begin
          state_d = DATA;
          beat_d  = 6'd0;
        end
      end
      DATA: begin
        if (wvalid && wready) begin
          beat_d = beat_q + 6'd1;
          if (beat_q == 6'd63) state_d = RESP;
        end
      end
      RESP: begin
        if (bvalid) begin
          if (bresp != 2'b00) err_d = 1'b1;
          page_d = page_inc;
          // An abort only takes effect here, so a started burst always completes.
          if (!scrb_enable)           state_d = IDLE;
          else if (page_inc >= end_q) state_d = DONE;
          else                        state_d = ADDR;
        end
      end
      DONE: begin
        if (!scrb_enable) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Channel strobes are registered from the next state so every output comes from a flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      en_q      <= 1'b0;
      start_q   <= 1'b0;
      page_q    <= '0;
      end_q     <= '0;
      pat_q     <= '0;
      beat_q    <= '0;
      scrb_err  <= 1'b0;
      scrb_done <= 1'b0;
      awvalid   <= 1'b0;
      wvalid    <= 1'b0;
      wlast     <= 1'b0;
      bready    <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      state_q   <= state_d;
      en_q      <= scrb_enable;
      start_q   <= scrb_enable & ~en_q;
      page_q    <= page_d;
      end_q     <= end_d;
      pat_q     <= pat_d;
      beat_q    <= beat_d;
      scrb_err  <= err_d;
      scrb_done <= (state_d == DONE);
      awvalid   <= (state_d == ADDR);
      wvalid    <= (state_d == DATA);
      wlast     <= (state_d == DATA) && (beat_d == 6'd63);
      bready    <= (state_d == RESP);
    end
  end

  assign scrb_addr  = {page_q, 12'h000};
  assign scrb_state = state_q;
  assign awid       = AXI_ID;
  assign awaddr     = {page_q, 12'h000};
  assign awlen      = 8'd63;
  assign awsize     = 3'b110;
  assign wid        = AXI_ID;
  assign wdata      = {16{pat_q}};
  assign wstrb      = {64{1'b1}};

endmodule

// File: tb/tb_cl_ddr_scrubber.sv
// Self-checking bench for cl_ddr_scrubber: an AXI write-slave model with optional
// random stalls, and a scoreboard of expected burst addresses.
module tb_cl_ddr_scrubber;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         scrb_enable = 1'b0;
  logic [63:0]  scrb_start = '0;
  logic [63:0]  scrb_end = '0;
  logic [31:0]  scrb_pattern = '0;
  logic [63:0]  scrb_addr;
  logic [2:0]   scrb_state;
  logic         scrb_done;
  logic         scrb_err;
  logic [15:0]  awid;
  logic [63:0]  awaddr;
  logic [7:0]   awlen;
  logic [2:0]   awsize;
  logic         awvalid;
  logic         awready = 1'b0;
  logic [15:0]  wid;
  logic [511:0] wdata;
  logic [63:0]  wstrb;
  logic         wlast;
  logic         wvalid;
  logic         wready = 1'b0;
  logic [15:0]  bid = 16'h0;
  logic [1:0]   bresp = 2'b00;
  logic         bvalid = 1'b0;
  logic         bready;

  cl_ddr_scrubber dut (
    .clk(clk), .rst_n(rst_n), .scrb_enable(scrb_enable), .scrb_start(scrb_start),
    .scrb_end(scrb_end), .scrb_pattern(scrb_pattern), .scrb_addr(scrb_addr),
    .scrb_state(scrb_state), .scrb_done(scrb_done), .scrb_err(scrb_err),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awvalid(awvalid),
    .awready(awready), .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .wvalid(wvalid), .wready(wready), .bid(bid), .bresp(bresp), .bvalid(bvalid),
    .bready(bready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [63:0]  exp_aw[$];
  logic [511:0] exp_wdata = '0;
  int stall_en = 0;
  int err_idx = -1;
  int aw_cnt = 0, w_total = 0, w_beat = 0, wb_done = 0, b_cnt = 0;
  int aw_wait = 0, w_wait = 0, b_wait = 0;
  bit aw_act = 0, w_act = 0, b_act = 0, aw_hold = 0, w_hold = 0;
  logic [63:0]  aw_prev = '0;
  logic [511:0] w_prev_data = '0;
  logic         w_prev_last = 1'b0;

  // Slave model: decides ready/valid 1 time unit after each edge; a handshake
  // recorded here completes on the following rising edge.
  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      awready = 0; wready = 0; bvalid = 0; bresp = 2'b00;
      aw_act = 0; w_act = 0; b_act = 0; aw_hold = 0; w_hold = 0;
    end else begin
      if (awvalid) begin
        if (aw_hold) begin
          checks++;
          if (awaddr !== aw_prev) begin
            failures++;
            $display("FAIL aw_stable awaddr=%h held=%h", awaddr, aw_prev);
          end
        end
        if (!aw_act) begin
          aw_act = 1;
          aw_wait = (stall_en != 0) ? int'($urandom_range(0, 7)) : 0;
        end
        if (aw_wait > 0) begin
          awready = 0; aw_wait--; aw_hold = 1; aw_prev = awaddr;
        end else begin
          logic [63:0] e;
          awready = 1; aw_act = 0; aw_hold = 0; aw_cnt++;
          checks++;
          if (exp_aw.size() == 0) begin
            failures++;
            $display("FAIL aw_unexpected awaddr=%h expected none", awaddr);
          end else begin
            e = exp_aw.pop_front();
            if (awaddr !== e || awlen !== 8'd63 || awsize !== 3'b110 || awid !== 16'h0) begin
              failures++;
              $display("FAIL aw_payload awaddr=%h awlen=%0d awsize=%0d awid=%h expected %h/63/6/0",
                       awaddr, awlen, awsize, awid, e);
            end
          end
        end
      end else begin
        awready = 0; aw_act = 0; aw_hold = 0;
      end

      if (wvalid) begin
        checks++;
        if (aw_cnt <= wb_done) begin
          failures++;
          $display("FAIL w_before_aw aw_count=%0d bursts_done=%0d", aw_cnt, wb_done);
        end
        if (w_hold) begin
          checks++;
          if (wdata !== w_prev_data || wlast !== w_prev_last) begin
            failures++;
            $display("FAIL w_stable wlast=%b held=%b", wlast, w_prev_last);
          end
        end
        if (!w_act) begin
          w_act = 1;
          w_wait = (stall_en != 0) ? int'($urandom_range(0, 7)) : 0;
        end
        if (w_wait > 0) begin
          wready = 0; w_wait--; w_hold = 1; w_prev_data = wdata; w_prev_last = wlast;
        end else begin
          wready = 1; w_act = 0; w_hold = 0;
          checks++;
          if (wdata !== exp_wdata || wlast !== (w_beat == 63) || wstrb !== {64{1'b1}} || wid !== 16'h0) begin
            failures++;
            $display("FAIL w_beat beat=%0d wlast=%b wdata[31:0]=%h expected wlast=%b wdata[31:0]=%h",
                     w_beat, wlast, wdata[31:0], (w_beat == 63), exp_wdata[31:0]);
          end
          w_total++; w_beat++;
          if (w_beat == 64) begin wb_done++; w_beat = 0; end
        end
      end else begin
        wready = 0; w_act = 0; w_hold = 0;
      end

      if (bready) begin
        if (!b_act) begin
          b_act = 1;
          b_wait = (stall_en != 0) ? int'($urandom_range(0, 7)) : 0;
        end
        if (b_wait > 0) begin
          bvalid = 0; b_wait--;
        end else begin
          bvalid = 1; bresp = (b_cnt == err_idx) ? 2'b10 : 2'b00; b_act = 0;
          checks++;
          if (wb_done != b_cnt + 1) begin
            failures++;
            $display("FAIL b_order bursts_done=%0d responses=%0d", wb_done, b_cnt);
          end
          b_cnt++;
        end
      end else begin
        bvalid = 0; bresp = 2'b00; b_act = 0;
      end
    end
  end

  task automatic clear_sb();
    exp_aw.delete();
    aw_cnt = 0; w_total = 0; w_beat = 0; wb_done = 0; b_cnt = 0;
  endtask

  task automatic start_scrub(input logic [63:0] s, input logic [63:0] e, input logic [31:0] p);
    logic [63:0] a;
    clear_sb();
    exp_wdata = {16{p}};
    a = {s[63:12], 12'h000};
    while (a[63:12] < e[63:12]) begin
      exp_aw.push_back(a);
      a += 64'h1000;
    end
    scrb_start = s; scrb_end = e; scrb_pattern = p; scrb_enable = 1'b1;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (scrb_done !== 1'b1 && n < 5000) begin
      @(posedge clk); #2; n++;
    end
    checks++;
    if (scrb_done !== 1'b1) begin
      failures++;
      $display("FAIL %s_timeout scrb_done=%b state=%0d", name, scrb_done, scrb_state);
    end
  endtask

  task automatic check_result(input string name, input int n_aw, input logic [63:0] addr);
    checks++;
    if (aw_cnt != n_aw || w_total != 64 * n_aw || b_cnt != n_aw || exp_aw.size() != 0 ||
        scrb_addr !== addr || scrb_state !== 3'd4) begin
      failures++;
      $display("FAIL %s_result aw=%0d beats=%0d b=%0d left=%0d addr=%h state=%0d expected aw=%0d beats=%0d addr=%h state=4",
               name, aw_cnt, w_total, b_cnt, exp_aw.size(), scrb_addr, scrb_state, n_aw, 64 * n_aw, addr);
    end
  endtask

  task automatic stop_scrub(input string name);
    scrb_enable = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (scrb_state !== 3'd0 || scrb_done !== 1'b0) begin
      failures++;
      $display("FAIL %s_stop state=%0d done=%b expected 0/0", name, scrb_state, scrb_done);
    end
  endtask

  task automatic test_reset();
    checks++;
    if (awvalid !== 1'b0 || wvalid !== 1'b0 || wlast !== 1'b0 || bready !== 1'b0 ||
        scrb_addr !== 64'h0 || scrb_state !== 3'd0 || scrb_done !== 1'b0 || scrb_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_values awv=%b wv=%b wl=%b br=%b addr=%h state=%0d done=%b err=%b expected all 0",
               awvalid, wvalid, wlast, bready, scrb_addr, scrb_state, scrb_done, scrb_err);
    end
  endtask

  task automatic test_basic();
    @(posedge clk); #2;
    start_scrub(64'h0, 64'h3000, 32'hA5A5_0001);
    @(posedge clk); #2;
    checks++;
    if (awvalid !== 1'b0 || scrb_state !== 3'd0) begin
      failures++;
      $display("FAIL basic_latency1 awvalid=%b state=%0d expected 0/0", awvalid, scrb_state);
    end
    @(posedge clk); #2;
    checks++;
    if (awvalid !== 1'b1 || scrb_state !== 3'd1 || scrb_addr !== 64'h0) begin
      failures++;
      $display("FAIL basic_latency2 awvalid=%b state=%0d addr=%h expected 1/1/0", awvalid, scrb_state, scrb_addr);
    end
    wait_done("basic");
    check_result("basic", 3, 64'h3000);
    checks++;
    if (scrb_err !== 1'b0) begin
      failures++;
      $display("FAIL basic_err scrb_err=%b expected 0", scrb_err);
    end
    stop_scrub("basic");
  endtask

  task automatic test_empty();
    start_scrub(64'h1FFF, 64'h1800, 32'h1234_5678);
    wait_done("empty");
    check_result("empty", 0, 64'h1000);
    stop_scrub("empty");
    start_scrub(64'h0FFF, 64'h1001, 32'h0BAD_F00D);
    wait_done("unaligned");
    check_result("unaligned", 1, 64'h1000);
    stop_scrub("unaligned");
  endtask

  task automatic test_backpressure();
    stall_en = 1;
    start_scrub(64'h1_0000, 64'h1_2000, 32'hDEAD_BEEF);
    wait_done("backpressure");
    check_result("backpressure", 2, 64'h1_2000);
    stop_scrub("backpressure");
    stall_en = 0;
  endtask

  task automatic test_abort();
    int n = 0;
    start_scrub(64'h4_0000, 64'h4_4000, 32'h5555_AAAA);
    while (w_total < 10 && n < 2000) begin @(posedge clk); #2; n++; end
    scrb_enable = 1'b0;
    n = 0;
    while (!(b_cnt >= 1 && scrb_state === 3'd0) && n < 2000) begin @(posedge clk); #2; n++; end
    repeat (20) @(posedge clk);
    #2;
    checks++;
    if (aw_cnt != 1 || w_total != 64 || b_cnt != 1 || exp_aw.size() != 3 ||
        scrb_state !== 3'd0 || scrb_done !== 1'b0 || awvalid !== 1'b0) begin
      failures++;
      $display("FAIL abort_drain aw=%0d beats=%0d b=%0d left=%0d state=%0d done=%b expected 1/64/1/3/0/0",
               aw_cnt, w_total, b_cnt, exp_aw.size(), scrb_state, scrb_done);
    end
    start_scrub(64'h4_0000, 64'h4_4000, 32'h5555_AAAA);
    wait_done("abort_restart");
    check_result("abort_restart", 4, 64'h4_4000);
    stop_scrub("abort_restart");
  endtask

  task automatic test_error();
    err_idx = 1;
    start_scrub(64'h8_0000, 64'h8_3000, 32'h0F0F_F0F0);
    wait_done("error");
    check_result("error", 3, 64'h8_3000);
    checks++;
    if (scrb_err !== 1'b1) begin
      failures++;
      $display("FAIL error_sticky scrb_err=%b expected 1", scrb_err);
    end
    stop_scrub("error");
    err_idx = -1;
    checks++;
    if (scrb_err !== 1'b1) begin
      failures++;
      $display("FAIL error_hold_idle scrb_err=%b expected 1", scrb_err);
    end
    start_scrub(64'h9_0000, 64'h9_1000, 32'h1111_2222);
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (scrb_err !== 1'b0) begin
      failures++;
      $display("FAIL error_clear scrb_err=%b expected 0", scrb_err);
    end
    wait_done("error_clean");
    check_result("error_clean", 1, 64'h9_1000);
    stop_scrub("error_clean");
  endtask

  task automatic test_reset_mid();
    int n = 0;
    start_scrub(64'hA_0000, 64'hA_4000, 32'hCAFE_0000);
    while (w_total < 30 && n < 2000) begin @(posedge clk); #2; n++; end
    #3;
    rst_n = 1'b0;
    scrb_enable = 1'b0;
    #1;
    checks++;
    if (awvalid !== 1'b0 || wvalid !== 1'b0 || wlast !== 1'b0 || bready !== 1'b0 ||
        scrb_addr !== 64'h0 || scrb_state !== 3'd0 || scrb_done !== 1'b0 || scrb_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid awv=%b wv=%b br=%b addr=%h state=%0d expected all 0",
               awvalid, wvalid, bready, scrb_addr, scrb_state);
    end
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b1;
    clear_sb();
    repeat (5) @(posedge clk);
    #2;
    checks++;
    if (scrb_state !== 3'd0 || awvalid !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_idle state=%0d awvalid=%b expected 0/0", scrb_state, awvalid);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #2;
    test_reset();
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    test_basic();
    test_empty();
    test_backpressure();
    test_abort();
    test_error();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cl_ddr_scrubber.md
# cl_ddr_scrubber

Write-only AXI master that initializes (scrubs) a DDR address range by issuing full 4 KiB write bursts of a replicated 32-bit pattern. It sits between the custom-logic config/status registers (scrb_bus enable/addr/state/done) and one DDR AXI port. It sequences one burst at a time and reports progress and completion. Read channels of the AXI port are not driven by this block; the top level ties them off.

## Interface
- AXI_ID, default 16'h0, constant awid/wid value.
- clk  in  1  design clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- scrb_enable  in  1  level; rising edge starts a scrub, low aborts after the current burst.
- scrb_start  in  64  first byte address; bits [11:0] ignored (treated as 0).
- scrb_end  in  64  exclusive end byte address; bits [11:0] ignored.
- scrb_pattern  in  32  data word, replicated 16x into wdata.
- scrb_addr  out  64  address of the burst in progress, or next-to-issue.
- scrb_state  out  3  current FSM state encoding.
- scrb_done  out  1  range fully written; held until scrb_enable low.
- scrb_err  out  1  sticky: some bresp != 2'b00 since last start.
- awid/awaddr/awlen/awsize/awvalid  out  16/64/8/3/1  write address channel.
- awready  in  1.
- wid/wdata/wstrb/wlast/wvalid  out  16/512/64/1/1  write data channel.
- wready  in  1.
- bid/bresp/bvalid  in  16/2/1;  bready  out  1.

## Operation
- Constants: awlen=8'd63, awsize=3'b110 (64 B), wstrb=all ones, awid=wid=AXI_ID, wdata={16{scrb_pattern}}; burst = 4096 B.
- States (scrb_state): IDLE=0, ADDR=1, DATA=2, RESP=3, DONE=4.
- IDLE: on scrb_enable 0->1 (registered edge detect): load scrb_addr=start[63:12]<<12, latch end and pattern, clear scrb_err. If start page >= end page -> DONE, else -> ADDR.
- ADDR: awvalid=1, awaddr=scrb_addr. On awvalid&awready -> DATA, beat counter=0.
- DATA: wvalid=1; wlast=1 when beat counter=63. Each wvalid&wready increments counter; handshake with wlast -> RESP. No W beat is issued before its AW handshake.
- RESP: bready=1. On bvalid: if bresp!=0 set scrb_err; scrb_addr += 4096. Then: if scrb_enable low -> IDLE; else if new scrb_addr >= end -> DONE; else -> ADDR.
- DONE: scrb_done=1; on scrb_enable low -> IDLE (scrb_done cleared). scrb_addr holds the final value (first unwritten address).
- Abort: scrb_enable dropping in ADDR/DATA/RESP never truncates a burst: AW, all 64 beats and B complete, then IDLE with scrb_done=0. Re-raising scrb_enable restarts from scrb_start.
- bid is ignored (single ID, one burst outstanding).
- Address compare is unsigned on full 64 bits; scrb_addr wrap past 2^64 is not supported (end <= 2^64-4096 by software contract).

## Timing
- Reset: awvalid=wvalid=wlast=bready=0, scrb_addr=0, scrb_state=IDLE, scrb_done=0, scrb_err=0, beat counter=0.
- All outputs registered. scrb_enable rising at edge N -> awvalid high after edge N+2 (edge detect + state register).
- awvalid, wvalid hold with stable payload until handshake (AXI rule); never deasserted early, including on abort.
- Minimum burst time with zero-wait slaves: 1 AW cycle + 64 W cycles + 1 B cycle (bvalid same cycle as entering RESP) + 1 turnaround = 67 cycles per 4 KiB.
- scrb_addr updates the cycle after the B handshake; scrb_done asserts in the cycle after the last B handshake.
- Asynchronous reset in any state returns immediately to reset values; a partially issued burst is abandoned (DDR-side reset is the system's responsibility).

## Test plan
- Basic: start=0x0, end=0x3000, pattern=0xA5A5_0001, zero-wait slave -> 3 AW with awaddr 0x0/0x1000/0x2000, awlen=63, 192 W beats all wdata={16{0xA5A50001}}, wlast every 64th; scrb_done=1, scrb_addr=0x3000.
- Unaligned/empty range: start=0x1FFF, end=0x1800 -> DONE with zero AXI traffic; start=0x0FFF, end=0x1001 -> one burst at 0x0, scrb_addr=0x1000.
- Backpressure: random awready/wready/bvalid stalls (0-7 cycles) on 2-page range -> payload stable during stalls, exactly 128 beats, no W before AW.
- Abort: drop scrb_enable at beat 10 of burst 1 of 4 -> burst completes (64 beats + B), state IDLE, scrb_done=0, no further AW; re-enable restarts at scrb_start.
- Error: bresp=2'b10 on burst 2 of 3 -> scrb_err=1, scrub continues to DONE; next start clears scrb_err.
- Reset mid-DATA: assert rst_n=0 at beat 30 -> all outputs at reset values same cycle, state IDLE.
